// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider / tick generator.
// Divides clk by a runtime-loadable divisor D and produces a 50%-duty square wave (out),
// a one-cycle strobe at each terminal count (tick), a RUN indicator (busy) and the live count.
// Continuous and one-shot (start/busy) modes are supported.
// Optional macro CLKDIV_PRESCALE_EN adds a PRESCALE-bit prescaler in front of the main counter,
// stretching the period to D * 2^PRESCALE clk cycles while tick stays one clk cycle wide.

module clk_div_prog #(
    parameter int unsigned WIDTH    = 17,
    parameter int unsigned RST_DIV  = 65536,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             one_shot,
    input  logic             start,
    output logic             out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic [WIDTH-1:0] RstDiv = WIDTH'(RST_DIV);

    state_e           state_q;
    logic [WIDTH-1:0] div_reg_q;
    logic [WIDTH-1:0] div_pend_q;
    logic             pend_q;
    logic             mode_q;
    logic [WIDTH-1:0] count_q;
    logic             out_q;
    logic             tick_q;
    logic             busy_q;

    logic [WIDTH-1:0] term_val;
    logic             at_term;
    logic             step;
    logic             enter_run;

    // Terminal value is D-1; divisors 0 and 1 both collapse to divide-by-1 (terminal 0).
    always_comb begin
        term_val = '0;
        if (div_reg_q > WIDTH'(1)) begin
            term_val = div_reg_q - WIDTH'(1);
        end
        at_term   = (count_q == term_val);
        enter_run = En && (!one_shot || start);
    end

`ifdef CLKDIV_PRESCALE_EN
    logic [PRESCALE-1:0] pre_q;

    // Prescaler is held at zero in IDLE, so it is clear on the entry edge, and free-runs in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (state_q == StIdle) begin
            pre_q <= '0;
        end else if (En) begin
            pre_q <= pre_q + PRESCALE'(1);
        end
    end

    // Main counter advances only when the prescaler is about to wrap.
    always_comb begin
        step = En && (&pre_q);
    end
`else
    logic unused_prescale;

    // Without the prescaler every enabled RUN edge advances the counter.
    always_comb begin
        step            = En;
        unused_prescale = ^PRESCALE;
    end
`endif

    // Control FSM with counter, divisor staging and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            div_reg_q  <= RstDiv;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            mode_q     <= 1'b0;
            count_q    <= '0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // No period is in flight, so a new divisor applies at once.
                    if (div_load) begin
                        div_reg_q <= div_in;
                        pend_q    <= 1'b0;
                    end
                    if (enter_run) begin
                        state_q <= StRun;
                        mode_q  <= one_shot;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (step) begin
                        if (at_term) begin
                            count_q <= '0;
                            out_q   <= ~out_q;
                            tick_q  <= 1'b1;
                            if (pend_q) begin
                                div_reg_q <= div_pend_q;
                            end
                            pend_q <= 1'b0;
                            if (mode_q) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            count_q <= count_q + WIDTH'(1);
                        end
                    end
                    // A load during RUN, even on the terminal edge, waits for the next
                    // terminal count; a later load overwrites an earlier one.
                    if (div_load) begin
                        div_pend_q <= div_in;
                        pend_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule
